cp0_intc: RTL and testbench
===========================

# cp0_intc

Parametrised coprocessor-0 for the multi-cycle MIPS core. It holds Status/Cause/EPC, accepts synchronous exceptions and vectored external interrupts with per-source masking, and supports two-level exception nesting through an IE stack. An optional Count/Compare timer raises an internal interrupt. It sits beside GPR/PC and is driven by the control unit's `ctrl_cp0_*` strobes.

## Interface
- `NUM_IRQ`, 6: number of external interrupt lines, 1..8.
- `EXC_VECTOR`, 32'h0000_0004: handler entry address.
- `TIMER_DIV`, 2: clk cycles per Count increment, ≥1.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mfc0` in 1: read strobe; `rdata` is 0 when low.
- `mtc0` in 1: write `wdata` to register `rd`.
- `pc` in 32: current instruction address.
- `rd` in 5: CP0 register select.
- `wdata` in 32: write data (rt).
- `exception` in 1: raise exception with code `cause`.
- `eret` in 1: return from exception.
- `cause` in 5: exception code: 0 = interrupt, 8 = syscall, 9 = break, 13 = teq.
- `irq` in NUM_IRQ: level-sensitive external interrupt lines.
- `rdata` out 32: combinational read of register `rd`.
- `status` out 32: Status register.
- `int_req` out 1: enabled interrupt pending; combinational.
- `timer_int` out 1: timer interrupt pending, Cause[30].
- `exc_addr` out 32: registered redirect address.

## Operation
- Implemented registers: Count (9), Compare (11), Status (12), Cause (13), EPC (14). All others read 0; writes to them are ignored.
- Status bits:
  - [2:0]: IE stack; bit 0 is the current IE.
  - [8], [9], [11]: mask bits for syscall, break and teq; 1 = masked.
  - [16+i]: enable for irq i.
  - [30]: timer interrupt enable.
  - Other bits are plain R/W storage.
- Cause bits:
  - [6:2]: ExcCode.
  - [16+i]: irq i, sampled every cycle.
  - [30]: TI.
  - Read-only to mtc0.
- Interrupt request: `int_req` = Status[0] & (|(Cause[16+:NUM_IRQ] & Status[16+:NUM_IRQ]) | (Cause[30] & Status[30])).
- Exception acceptance:
  - cause 8, 9 or 13 is accepted when Status[0]=1 and its mask bit is 0.
  - cause 0 is accepted when `int_req`=1.
  - Any other code is accepted when Status[0]=1.
- On accept:
  - Status[2:0] ← {Status[1:0], 0}.
  - Cause[6:2] ← `cause`.
  - EPC ← `pc`.
  - `exc_addr` ← EXC_VECTOR.
- On reject: `exc_addr` ← `pc`; no other state changes.
- On eret: Status[2:0] ← {1, Status[2:1]}; `exc_addr` ← EPC.
- Write priority per cycle: `rst` > `exception` > `eret` > `mtc0`. Only one of these acts per cycle.
- IRQ sampling into Cause and timer counting proceed in every non-reset cycle, independent of the write priority above.

## Timing
- Reset (synchronous): all registers, the prescaler and `exc_addr` go to 0. Therefore `status`, `timer_int` and `int_req` read 0.
- All register updates take effect on the clock edge; `rdata` and `int_req` reflect the new values in the next cycle.
- IRQ latency: a change on `irq` is visible in Cause/`int_req` one cycle later. No latching: deasserting `irq` clears the pending bit.
- Count increments when the prescaler reaches TIMER_DIV-1; the prescaler then wraps to 0. Count wraps from 32'hFFFF_FFFF to 0.
- TI is set on the edge where Count increments to a value equal to Compare. It stays set until mtc0 writes Compare.
- mtc0 to Count loads `wdata` and clears the prescaler; that cycle's increment is suppressed.
- mtc0 to Compare in the same cycle as a match: the write wins and TI ends cleared.
- Exception accepted while Status[0]=0 is impossible. Nesting depth is therefore bounded by software re-enabling IE, and the stack holds three IE levels.
- `exception` and `eret` asserted together: `exception` wins and `eret` is dropped.
- `rst` mid-handler discards EPC and all stack state.

## Configuration
- `CP0_TIMER_EN` defined:
  - Count/Compare, the prescaler and TI are present.
  - `timer_int` = Cause[30].
- Not defined:
  - Registers 9 and 11 read 0 and ignore writes.
  - Cause[30] is held at 0 and `timer_int` is tied to 0.
  - TIMER_DIV is unused.

## Test plan
- Reset: after `rst`, expect `status`, `exc_addr`, `timer_int` and `int_req` all 0, and mfc0 of regs 12/13/14 returns 0.
- Syscall accept then reject:
  - mtc0 Status=32'h1, then exception cause=8, pc=32'h100 → `exc_addr`=4, EPC=32'h100, Cause[6:2]=8, Status[2:0]=3'b010.
  - With Status=32'h101 instead → `exc_addr`=32'h100 and Status is unchanged.
- Nesting: Status[2:0]=3'b001, then accept, software sets IE, accept again → Status[2:0]=3'b010. First eret → 3'b101; second eret → 3'b110.
- External IRQ: Status=32'h0004_0001 (irq2 enabled), pulse irq[2] → `int_req` high one cycle later. exception cause=0 → `exc_addr`=4. Deassert irq[2] → Cause[18]=0.
- Timer (CP0_TIMER_EN, TIMER_DIV=2): Compare=5, Count=0, Status[30]=1 → `timer_int` rises 10 cycles after the Count write. mtc0 Compare=20 clears it.
- Priority: exception and eret together with mtc0 Status=0 → exception taken, eret and mtc0 ignored, Status[2:0] shifts by one.

Source files
------------

// File: rtl/cp0_intc.sv
// cp0_intc: coprocessor-0 for the multi-cycle MIPS core.
// Holds Status/Cause/EPC, takes synchronous exceptions and masked vectored
// external interrupts, and keeps a three-level IE stack in Status[2:0] so a
// handler can re-enable interrupts and be nested once more.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined; without
// it registers 9/11 read 0, Cause[30] stays 0 and timer_int is tied low.
module cp0_intc #(
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
  parameter int          TIMER_DIV  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mfc0,
  input  logic               mtc0,
  input  logic [31:0]        pc,
  input  logic [4:0]         rd,
  input  logic [31:0]        wdata,
  input  logic               exception,
  input  logic               eret,
  input  logic [4:0]         cause,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        rdata,
  output logic [31:0]        status,
  output logic               int_req,
  output logic               timer_int,
  output logic [31:0]        exc_addr
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  logic [31:0]        status_q;
  logic [31:0]        epc_q;
  logic [31:0]        exc_addr_q;
  logic [4:0]         exc_code_q;
  logic [NUM_IRQ-1:0] irq_q;
  logic               ti_q;
  logic [31:0]        cause_val;
  logic               accept;
  logic               mtc0_act;

  // mtc0 only acts when neither exception nor eret claims the cycle
  assign mtc0_act = mtc0 & ~exception & ~eret;

  assign int_req = status_q[0] &
                   ((|(irq_q & status_q[16 +: NUM_IRQ])) | (ti_q & status_q[30]));

  // Assemble the architectural view of Cause from its live fields
  always_comb begin
    cause_val                 = '0;
    cause_val[6:2]            = exc_code_q;
    cause_val[16 +: NUM_IRQ]  = irq_q;
    cause_val[30]             = ti_q;
  end

  // Decide whether the requested exception is taken this cycle
  always_comb begin
    accept = 1'b0;
    case (cause)
      5'd0:    accept = int_req;
      5'd8:    accept = status_q[0] & ~status_q[8];
      5'd9:    accept = status_q[0] & ~status_q[9];
      5'd13:   accept = status_q[0] & ~status_q[11];
      default: accept = status_q[0];
    endcase
  end

  // Status/Cause/EPC/redirect state; exception beats eret beats mtc0
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= '0;
      epc_q      <= '0;
      exc_addr_q <= '0;
      exc_code_q <= '0;
      irq_q      <= '0;
    end else begin
      irq_q <= irq;
      if (exception) begin
        if (accept) begin
          status_q[2:0] <= {status_q[1:0], 1'b0};
          exc_code_q    <= cause;
          epc_q         <= pc;
          exc_addr_q    <= EXC_VECTOR;
        end else begin
          exc_addr_q    <= pc;
        end
      end else if (eret) begin
        status_q[2:0] <= {1'b1, status_q[2:1]};
        exc_addr_q    <= epc_q;
      end else if (mtc0_act && rd == REG_STATUS) begin
        status_q <= wdata;
      end else if (mtc0_act && rd == REG_EPC) begin
        epc_q <= wdata;
      end
    end
  end

`ifdef CP0_TIMER_EN
  localparam int PRESC_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [PRESC_W-1:0] presc_q;
  logic [31:0]        count_q;
  logic [31:0]        compare_q;
  logic [31:0]        count_inc;
  logic               tick;
  logic               count_wr;
  logic               compare_wr;

  assign count_wr   = mtc0_act & (rd == REG_COUNT);
  assign compare_wr = mtc0_act & (rd == REG_COMPARE);
  assign tick       = (presc_q == PRESC_W'(TIMER_DIV - 1));
  assign count_inc  = count_q + 32'd1;

  // Prescaler and Count; a software load restarts the prescale period
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      count_q <= '0;
    end else if (count_wr) begin
      presc_q <= '0;
      count_q <= wdata;
    end else if (tick) begin
      presc_q <= '0;
      count_q <= count_inc;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  // Compare register
  always_ff @(posedge clk) begin
    if (rst) begin
      compare_q <= '0;
    end else if (compare_wr) begin
      compare_q <= wdata;
    end
  end

  // TI is sticky until software rewrites Compare, which also beats a match
  always_ff @(posedge clk) begin
    if (rst) begin
      ti_q <= 1'b0;
    end else if (compare_wr) begin
      ti_q <= 1'b0;
    end else if (tick && !count_wr && count_inc == compare_q) begin
      ti_q <= 1'b1;
    end
  end
`else
  assign ti_q = 1'b0;
`endif

  // Combinational mfc0 read port; unimplemented registers read as zero
  always_comb begin
    rdata = '0;
    if (mfc0) begin
      case (rd)
`ifdef CP0_TIMER_EN
        REG_COUNT:   rdata = count_q;
        REG_COMPARE: rdata = compare_q;
`endif
        REG_STATUS:  rdata = status_q;
        REG_CAUSE:   rdata = cause_val;
        REG_EPC:     rdata = epc_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign status    = status_q;
  assign exc_addr  = exc_addr_q;
  assign timer_int = ti_q;

endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed steps followed by randomized traffic for cp0_intc,
// compared every cycle against a register-level reference model.
module tb_cp0_intc;

  localparam int          N    = 6;
  localparam int          TDIV = 2;
  localparam logic [31:0] VEC  = 32'h0000_0004;
`ifdef CP0_TIMER_EN
  localparam bit HAS_TIMER = 1'b1;
`else
  localparam bit HAS_TIMER = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         mfc0;
  logic         mtc0;
  logic [31:0]  pc;
  logic [4:0]   rd;
  logic [31:0]  wdata;
  logic         exception;
  logic         eret;
  logic [4:0]   cause;
  logic [N-1:0] irq;
  logic [31:0]  rdata;
  logic [31:0]  status;
  logic         int_req;
  logic         timer_int;
  logic [31:0]  exc_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0]  m_status;
  logic [4:0]   m_code;
  logic [N-1:0] m_irq;
  logic         m_ti;
  logic [31:0]  m_epc;
  logic [31:0]  m_addr;
  logic [31:0]  m_count;
  logic [31:0]  m_compare;
  int           m_pre;
  bit           m_valid = 1'b0;

  cp0_intc #(.NUM_IRQ(N), .EXC_VECTOR(VEC), .TIMER_DIV(TDIV)) dut (
    .clk(clk), .rst(rst), .mfc0(mfc0), .mtc0(mtc0), .pc(pc), .rd(rd),
    .wdata(wdata), .exception(exception), .eret(eret), .cause(cause),
    .irq(irq), .rdata(rdata), .status(status), .int_req(int_req),
    .timer_int(timer_int), .exc_addr(exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_int_req();
    return m_status[0] &&
           (((m_irq & m_status[16 +: N]) != '0) || (m_ti && m_status[30]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    logic [31:0] v;
    v = 32'h0;
    case (r)
      5'd9:  if (HAS_TIMER) v = m_count;
      5'd11: if (HAS_TIMER) v = m_compare;
      5'd12: v = m_status;
      5'd13: begin
        v[6:2]       = m_code;
        v[16 +: N]   = m_irq;
        v[30]        = m_ti;
      end
      5'd14: v = m_epc;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1; mfc0 = 0; mtc0 = 0; pc = 0; rd = 0; wdata = 0;
    exception = 0; eret = 0; cause = 0; irq = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_status = 0; m_code = 0; m_irq = '0; m_ti = 0; m_epc = 0; m_addr = 0;
    m_count = 0; m_compare = 0; m_pre = 0; m_valid = 1'b1;
    checkOutput("rst_status", status, 32'h0);
    checkOutput("rst_exc_addr", exc_addr, 32'h0);
    checkOutput("rst_timer_int", {31'b0, timer_int}, 32'h0);
    checkOutput("rst_int_req", {31'b0, int_req}, 32'h0);
  endtask

  // combinational read without a clock edge
  task automatic peek(input string tag, input logic [4:0] r, input logic [31:0] exp);
    mfc0 = 1'b1; rd = r; mtc0 = 0; exception = 0; eret = 0;
    #1;
    checkOutput(tag, rdata, exp);
    mfc0 = 1'b0;
  endtask

  // one clock cycle: drive, check comb outputs, advance model, check state
  task automatic applyStimulus(input logic mf, input logic mt, input logic [4:0] r,
                               input logic [31:0] wd, input logic [31:0] p,
                               input logic ex, input logic er, input logic [4:0] cs,
                               input logic [N-1:0] iq);
    logic acc;
    bit   mt_ok;
    rst = 1'b0; mfc0 = mf; mtc0 = mt; rd = r; wdata = wd; pc = p;
    exception = ex; eret = er; cause = cs; irq = iq;
    #1;
    checkOutput("rdata", rdata, mf ? m_read(r) : 32'h0);
    checkOutput("int_req_pre", {31'b0, int_req}, {31'b0, m_int_req()});
    mt_ok = mt && !ex && !er;
    if (ex) begin
      if (cs == 5'd0)       acc = m_int_req();
      else if (cs == 5'd8)  acc = m_status[0] && !m_status[8];
      else if (cs == 5'd9)  acc = m_status[0] && !m_status[9];
      else if (cs == 5'd13) acc = m_status[0] && !m_status[11];
      else                  acc = m_status[0];
      if (acc) begin
        m_status[2:0] = {m_status[1:0], 1'b0};
        m_code = cs;
        m_epc  = p;
        m_addr = VEC;
      end else begin
        m_addr = p;
      end
    end else if (er) begin
      m_status[2:0] = {1'b1, m_status[2:1]};
      m_addr = m_epc;
    end else if (mt_ok && r == 5'd12) begin
      m_status = wd;
    end else if (mt_ok && r == 5'd14) begin
      m_epc = wd;
    end
    if (HAS_TIMER) begin
      if (mt_ok && r == 5'd9) begin
        m_count = wd;
        m_pre = 0;
      end else begin
        m_pre++;
        if (m_pre == TDIV) begin
          m_pre = 0;
          m_count++;
          if (m_count == m_compare) m_ti = 1'b1;
        end
      end
      if (mt_ok && r == 5'd11) begin
        m_compare = wd;
        m_ti = 1'b0;
      end
    end
    m_irq = iq;
    @(posedge clk); #1;
    checkOutput("status", status, m_status);
    checkOutput("exc_addr", exc_addr, m_addr);
    checkOutput("timer_int", {31'b0, timer_int}, {31'b0, m_ti});
    checkOutput("int_req", {31'b0, int_req}, {31'b0, m_int_req()});
  endtask

  initial begin
    logic [4:0]   r;
    logic [31:0]  wd;
    logic [N-1:0] iq;
    logic [4:0]   cs;

    doReset();
    peek("rst_rd12", 5'd12, 32'h0);
    peek("rst_rd13", 5'd13, 32'h0);
    applyStimulus(1, 0, 5'd14, 0, 0, 0, 0, 0, '0);

    $display("[TB] syscall accept / reject");
    applyStimulus(0, 1, 5'd12, 32'h1, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 5'd0, 0, 32'h100, 1, 0, 5'd8, '0);
    checkOutput("sys_exc_addr", exc_addr, 32'h4);
    checkOutput("sys_status", {29'b0, status[2:0]}, 32'h2);
    peek("sys_epc", 5'd14, 32'h100);
    peek("sys_cause", 5'd13, 32'd8 << 2);
    applyStimulus(0, 1, 5'd12, 32'h101, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 5'd0, 0, 32'h100, 1, 0, 5'd8, '0);
    checkOutput("rej_exc_addr", exc_addr, 32'h100);
    checkOutput("rej_status", status, 32'h101);

    $display("[TB] nesting");
    applyStimulus(0, 1, 5'd12, 32'h1, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 5'd0, 0, 32'h200, 1, 0, 5'd8, '0);
    applyStimulus(0, 1, 5'd12, 32'h1, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 5'd0, 0, 32'h300, 1, 0, 5'd9, '0);
    checkOutput("nest_acc2", {29'b0, status[2:0]}, 32'h2);
    applyStimulus(0, 0, 5'd0, 0, 0, 0, 1, 0, '0);
    checkOutput("nest_eret1", {29'b0, status[2:0]}, 32'h5);
    checkOutput("nest_eret1_addr", exc_addr, 32'h300);
    applyStimulus(0, 0, 5'd0, 0, 0, 0, 1, 0, '0);
    checkOutput("nest_eret2", {29'b0, status[2:0]}, 32'h6);

    $display("[TB] external irq");
    applyStimulus(0, 1, 5'd12, 32'h0004_0001, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 5'd0, 0, 0, 0, 0, 0, 6'b000100);
    checkOutput("irq_int_req", {31'b0, int_req}, 32'h1);
    applyStimulus(0, 0, 5'd0, 0, 32'h400, 1, 0, 5'd0, 6'b000100);
    checkOutput("irq_exc_addr", exc_addr, 32'h4);
    applyStimulus(0, 0, 5'd0, 0, 0, 0, 0, 0, 6'b000000);
    peek("irq_cleared", 5'd13, 32'h0);

`ifdef CP0_TIMER_EN
    $display("[TB] timer");
    applyStimulus(0, 1, 5'd11, 32'd5, 0, 0, 0, 0, '0);
    applyStimulus(0, 1, 5'd12, 32'h4000_0000, 0, 0, 0, 0, '0);
    applyStimulus(0, 1, 5'd9, 32'd0, 0, 0, 0, 0, '0);
    for (int k = 0; k < 9; k++) applyStimulus(0, 0, 5'd0, 0, 0, 0, 0, 0, '0);
    checkOutput("ti_before", {31'b0, timer_int}, 32'h0);
    applyStimulus(0, 0, 5'd0, 0, 0, 0, 0, 0, '0);
    checkOutput("ti_rise", {31'b0, timer_int}, 32'h1);
    applyStimulus(0, 1, 5'd11, 32'd20, 0, 0, 0, 0, '0);
    checkOutput("ti_clear", {31'b0, timer_int}, 32'h0);
`endif

    $display("[TB] priority");
    applyStimulus(0, 1, 5'd12, 32'h1, 0, 0, 0, 0, '0);
    applyStimulus(0, 1, 5'd12, 32'h0, 32'h500, 1, 1, 5'd8, '0);
    checkOutput("prio_status", status, 32'h2);
    checkOutput("prio_exc_addr", exc_addr, 32'h4);

    $display("[TB] reset mid-handler");
    doReset();
    peek("rst_epc", 5'd14, 32'h0);

    $display("[TB] random traffic");
    iq = '0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      case ($urandom_range(0, 7))
        0:       r = 5'd9;
        1:       r = 5'd11;
        2:       r = 5'd12;
        3:       r = 5'd13;
        4:       r = 5'd14;
        default: r = 5'($urandom);
      endcase
      wd = $urandom;
      if (r == 5'd9 || r == 5'd11) wd = $urandom_range(0, 30);
      if (r == 5'd12) wd[0] = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       cs = 5'd0;
        1:       cs = 5'd8;
        2:       cs = 5'd9;
        3:       cs = 5'd13;
        4:       cs = 5'd12;
        default: cs = 5'd4;
      endcase
      if ($urandom_range(0, 3) == 0) iq = N'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), r, wd,
                    {$urandom, 2'b00} >> 2 << 2,
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), cs, iq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
